// File: rtl/digit_reveal_serializer.sv
// digit_reveal_serializer
// Latches a 16-bit target number and presents it one hex digit at a time,
// MSB nibble first. Each digit is shown for ON_CYCLES clocks. A blank gap of
// GAP_CYCLES clocks follows each digit. All outputs are registered: each one
// reflects the state entered on the preceding clock edge.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start, display dark
// SHOW  | presenting nibble idx, digit_valid high
// GAP   | blank period after a digit (also after the last digit)
// DONE  | single-cycle completion, done pulses, then back to IDLE
module digit_reveal_serializer #(
  parameter int ON_CYCLES  = 50000000,
  parameter int GAP_CYCLES = 10000000,
  parameter int CNT_W      = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] value,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        digit_strobe,
  output logic        blank,
  output logic [1:0]  digit_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The phase counter counts up from 0. A phase ends on the cycle the
  // counter reaches its last value, so each phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       val_q, val_d;
  logic [3:0]        digit_q, digit_d;
  logic              digit_valid_q, digit_valid_d;
  logic              digit_strobe_q, digit_strobe_d;
  logic              blank_q, blank_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              new_digit;

  // Selects nibble i of v, where nibble 0 is the most significant one.
  function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = v[15:12];
      2'd1:    n = v[11:8];
      2'd2:    n = v[7:4];
      default: n = v[3:0];
    endcase
    return n;
  endfunction

  // Compute the next state, counter, digit index and latched value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    val_d     = val_q;
    new_digit = 1'b0;
    case (state_q)
      S_IDLE: begin
        // An abort in the same cycle as start drops the start.
        if (start && !abort) begin
          state_d   = S_SHOW;
          val_d     = value;
          idx_d     = 2'd0;
          cnt_d     = '0;
          new_digit = 1'b1;
        end
      end
      S_SHOW: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end else if (cnt_q == ON_LAST) begin
          cnt_d = '0;
          if (HAS_GAP) begin
            state_d = S_GAP;
          end else if (idx_q == 2'd3) begin
            state_d = S_DONE;
            idx_d   = 2'd0;
          end else begin
            idx_d     = idx_q + 2'd1;
            new_digit = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = S_DONE;
            idx_d   = 2'd0;
          end else begin
            state_d   = S_SHOW;
            idx_d     = idx_q + 2'd1;
            new_digit = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        // Abort is ignored here: the sequence has already completed.
        state_d = S_IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Derive the registered outputs from the state being entered.
  always_comb begin
    digit_valid_d  = (state_d == S_SHOW);
    digit_strobe_d = new_digit;
    blank_d        = (state_d != S_SHOW);
    busy_d         = (state_d == S_SHOW) || (state_d == S_GAP);
    done_d         = (state_d == S_DONE);
    case (state_d)
      S_SHOW:  digit_d = nibble_of(val_d, idx_d);
      S_IDLE:  digit_d = 4'h0;
      default: digit_d = digit_q;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      idx_q          <= 2'd0;
      val_q          <= 16'h0000;
      digit_q        <= 4'h0;
      digit_valid_q  <= 1'b0;
      digit_strobe_q <= 1'b0;
      blank_q        <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      val_q          <= val_d;
      digit_q        <= digit_d;
      digit_valid_q  <= digit_valid_d;
      digit_strobe_q <= digit_strobe_d;
      blank_q        <= blank_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign digit        = digit_q;
  assign digit_valid  = digit_valid_q;
  assign digit_strobe = digit_strobe_q;
  assign blank        = blank_q;
  assign digit_idx    = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_digit_reveal_serializer.sv
// Directed bench for digit_reveal_serializer. One instance uses a 3-cycle
// on-time with a 2-cycle gap, and a second instance uses a 3-cycle on-time
// with no gap.
module tb_digit_reveal_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [15:0] value;
  logic [3:0]  digit;
  logic        dv, ds, blank, busy, done;
  logic [1:0]  didx;

  logic        start_z, abort_z;
  logic [15:0] value_z;
  logic [3:0]  digit_z;
  logic        dv_z, ds_z, blank_z, busy_z, done_z;
  logic [1:0]  didx_z;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digit_reveal_serializer #(.ON_CYCLES(3), .GAP_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .value(value),
    .digit(digit), .digit_valid(dv), .digit_strobe(ds), .blank(blank),
    .digit_idx(didx), .busy(busy), .done(done)
  );

  digit_reveal_serializer #(.ON_CYCLES(3), .GAP_CYCLES(0), .CNT_W(4)) dut_z (
    .clk(clk), .rst(rst), .start(start_z), .abort(abort_z), .value(value_z),
    .digit(digit_z), .digit_valid(dv_z), .digit_strobe(ds_z), .blank(blank_z),
    .digit_idx(didx_z), .busy(busy_z), .done(done_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_digit"}, 0, {12'h0, digit}, 16'h0);
    chk({tag, "_valid"}, 0, {15'h0, dv}, 16'h0);
    chk({tag, "_strobe"}, 0, {15'h0, ds}, 16'h0);
    chk({tag, "_blank"}, 0, {15'h0, blank}, 16'h1);
    chk({tag, "_idx"}, 0, {14'h0, didx}, 16'h0);
    chk({tag, "_busy"}, 0, {15'h0, busy}, 16'h0);
    chk({tag, "_done"}, 0, {15'h0, done}, 16'h0);
  endtask

  // Full sequence on the gapped instance, start asserted in the current cycle
  // (cycle t). Optionally re-pulses start with a different value at t+7.
  task automatic run_seq(input logic [15:0] v, input bit repulse);
    int n, ph, ns, nd;
    bit sh;
    logic [15:0] tmp;
    ns = 0;
    nd = 0;
    start = 1'b1;
    value = v;
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (repulse && k == 7) begin start = 1'b1; value = 16'hFFFF; end
      if (repulse && k == 8) start = 1'b0;
      n  = (k - 1) / 5;
      ph = (k - 1) % 5;
      sh = (k <= 20) && (ph < 3);
      chk("seq_valid", k, {15'h0, dv}, {15'h0, sh});
      chk("seq_blank", k, {15'h0, blank}, {15'h0, !sh});
      chk("seq_strobe", k, {15'h0, ds}, {15'h0, sh && (ph == 0)});
      chk("seq_busy", k, {15'h0, busy}, {15'h0, k <= 20});
      chk("seq_done", k, {15'h0, done}, {15'h0, k == 21});
      if (sh) begin
        tmp = v >> (12 - 4 * n);
        chk("seq_digit", k, {12'h0, digit}, {12'h0, tmp[3:0]});
        chk("seq_idx", k, {14'h0, didx}, 16'(n));
      end
      ns += int'(ds);
      nd += int'(done);
    end
    for (int k = 22; k <= 25; k++) begin
      tick();
      chk("post_valid", k, {15'h0, dv}, 16'h0);
      chk("post_busy", k, {15'h0, busy}, 16'h0);
      chk("post_done", k, {15'h0, done}, 16'h0);
      chk("post_blank", k, {15'h0, blank}, 16'h1);
    end
    chk("strobe_count", 0, 16'(ns), 16'd4);
    chk("done_count", 0, 16'(nd), 16'd1);
  endtask

  initial begin
    int n;
    bit sh;
    logic [15:0] tmp;

    rst = 1'b1; start = 1'b0; abort = 1'b0; value = 16'h0;
    start_z = 1'b0; abort_z = 1'b0; value_z = 16'h0;
    tick();
    tick();
    chk_reset("por");
    chk("por_z_valid", 0, {15'h0, dv_z}, 16'h0);
    chk("por_z_blank", 0, {15'h0, blank_z}, 16'h1);
    rst = 1'b0;
    tick();

    // Basic reveal with start re-pulsed and value changed mid-sequence.
    run_seq(16'hA5C3, 1'b1);

    // Abort during SHOW of digit 2, then a fresh sequence.
    start = 1'b1;
    value = 16'hA5C3;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    chk("pre_abort_valid", 12, {15'h0, dv}, 16'h1);
    chk("pre_abort_digit", 12, {12'h0, digit}, 16'hC);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_reset("abort");
    for (int k = 14; k <= 24; k++) begin
      tick();
      chk("abort_quiet_done", k, {15'h0, done}, 16'h0);
      chk("abort_quiet_busy", k, {15'h0, busy}, 16'h0);
    end
    run_seq(16'h0001, 1'b0);

    // Abort together with start in IDLE: start is dropped.
    start = 1'b1;
    abort = 1'b1;
    value = 16'h7777;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("abort_start_busy", k, {15'h0, busy}, 16'h0);
      chk("abort_start_valid", k, {15'h0, dv}, 16'h0);
      tick();
    end

    // Reset during the gap after digit index 2.
    start = 1'b1;
    value = 16'h3C5A;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    chk("gap2_blank", 14, {15'h0, blank}, 16'h1);
    chk("gap2_busy", 14, {15'h0, busy}, 16'h1);
    chk("gap2_idx", 14, {14'h0, didx}, 16'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("midrst");
    run_seq(16'h9E07, 1'b0);

    // Zero-gap instance: 12 contiguous SHOW cycles, then done.
    start_z = 1'b1;
    value_z = 16'h1234;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1) start_z = 1'b0;
      n  = (k - 1) / 3;
      sh = (k <= 12);
      chk("z_valid", k, {15'h0, dv_z}, {15'h0, sh});
      chk("z_blank", k, {15'h0, blank_z}, {15'h0, !sh});
      chk("z_strobe", k, {15'h0, ds_z}, {15'h0, sh && ((k - 1) % 3 == 0)});
      chk("z_busy", k, {15'h0, busy_z}, {15'h0, sh});
      chk("z_done", k, {15'h0, done_z}, {15'h0, k == 13});
      if (sh) begin
        tmp = 16'h1234 >> (12 - 4 * n);
        chk("z_digit", k, {12'h0, digit_z}, {12'h0, tmp[3:0]});
        chk("z_idx", k, {14'h0, didx_z}, 16'(n));
      end
    end
    tick();
    chk("z_after_done", 14, {15'h0, done_z}, 16'h0);
    chk("z_after_busy", 14, {15'h0, busy_z}, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
